// File: rtl/vram_pkg.sv
// Shared types and width helpers for the playfield VRAM sequencer slice.
package vram_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_NUM_PF = 2;
    localparam int unsigned DEF_COL_W  = 6;
    localparam int unsigned DEF_VSCR_W = 9;

    // Slot index is kept generously wide so any legal NUM_PF fits.
    localparam int unsigned SLOT_W = 8;
    typedef logic [SLOT_W-1:0] slot_t;

    function automatic int unsigned calc_row_w(input int unsigned vscr_w);
        return vscr_w - 3;
    endfunction

    function automatic int unsigned calc_addr_w(input int unsigned num_pf,
                                                input int unsigned col_w,
                                                input int unsigned vscr_w);
        return int'($clog2(num_pf)) + calc_row_w(vscr_w) + col_w;
    endfunction

    localparam int unsigned ROW_W  = calc_row_w(DEF_VSCR_W);
    localparam int unsigned ADDR_W = calc_addr_w(DEF_NUM_PF, DEF_COL_W, DEF_VSCR_W);

endpackage

// File: rtl/pf_vram_sequencer_if.sv
// Bus bundle between the VRAM sequencer and its fetch/CPU/control clients.
interface pf_vram_sequencer_if
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NUM_PF = DEF_NUM_PF,
    parameter int unsigned COL_W  = DEF_COL_W,
    parameter int unsigned VSCR_W = DEF_VSCR_W
) ();

    localparam int unsigned AW = calc_addr_w(NUM_PF, COL_W, VSCR_W);

    logic [COL_W-1:0]         hcol_i;
    logic                     line_stb;
    logic [NUM_PF-1:0]        vscroll_ld;
    logic [VSCR_W-1:0]        vscroll_val;
    logic [AW-1:0]            mo_addr_i;
    logic                     cpu_req;
    logic                     cpu_we;
    logic [AW-1:0]            cpu_addr;
    logic [DATA_W-1:0]        cpu_wdata;
    logic                     cpu_ack;
    logic [DATA_W-1:0]        cpu_rdata;
    logic [NUM_PF*DATA_W-1:0] pf_data_o;
    logic [NUM_PF-1:0]        pf_valid_o;
    logic [NUM_PF*3-1:0]      pf_fine_o;
    logic [DATA_W-1:0]        mo_data_o;
    logic                     mo_valid_o;
    logic                     ctrl_we;
    logic [7:0]               ctrl_wdata;
    logic [7:0]               ctrl_o;

    modport slave (
        input  hcol_i, line_stb, vscroll_ld, vscroll_val, mo_addr_i,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, ctrl_we, ctrl_wdata,
        output cpu_ack, cpu_rdata, pf_data_o, pf_valid_o, pf_fine_o,
               mo_data_o, mo_valid_o, ctrl_o
    );

    modport master (
        output hcol_i, line_stb, vscroll_ld, vscroll_val, mo_addr_i,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, ctrl_we, ctrl_wdata,
        input  cpu_ack, cpu_rdata, pf_data_o, pf_valid_o, pf_fine_o,
               mo_data_o, mo_valid_o, ctrl_o
    );

endinterface

// File: rtl/vram_bank.sv
// Single-port VRAM array, synchronous read-first, one-cycle read latency.
module vram_bank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    // Contents are deliberately not reset so VRAM survives a system reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rd_q <= mem[addr];
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/pf_vram_sequencer.sv
// Time-slotted VRAM arbiter: one fetch slot per playfield, one motion-object
// slot and one CPU slot per round, plus per-playfield vertical scroll counters.
module pf_vram_sequencer
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NUM_PF = DEF_NUM_PF,
    parameter int unsigned COL_W  = DEF_COL_W,
    parameter int unsigned VSCR_W = DEF_VSCR_W
) (
    input  logic               clk,
    input  logic               rst,
    pf_vram_sequencer_if.slave bus
);

    localparam int unsigned S    = NUM_PF + 2;
    localparam int unsigned PF_W = $clog2(NUM_PF);
    localparam int unsigned RW   = calc_row_w(VSCR_W);
    localparam int unsigned AW   = calc_addr_w(NUM_PF, COL_W, VSCR_W);
    localparam slot_t LAST_SLOT  = slot_t'(S - 1);
    localparam slot_t MO_SLOT    = slot_t'(NUM_PF);
    localparam slot_t CPU_SLOT   = slot_t'(NUM_PF + 1);

    slot_t             slot_q, slot_d;
    logic [VSCR_W-1:0] vscr_q    [NUM_PF];
    logic [VSCR_W-1:0] vscr_d    [NUM_PF];
    logic [DATA_W-1:0] pf_hold_q [NUM_PF];
    logic [DATA_W-1:0] pf_hold_d [NUM_PF];
    logic [NUM_PF-1:0] pf_valid_q, pf_valid_d;
    logic              mo_valid_q, mo_valid_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] mo_hold_q, mo_hold_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [7:0]        ctrl_q, ctrl_d;

    logic              cpu_slot_c;
    logic              ram_en_c;
    logic              ram_we_c;
    logic [AW-1:0]     ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] ram_rdata;

    // Round-robin slot counter.
    always_comb begin
        slot_d = slot_q + slot_t'(1);
        if (slot_q == LAST_SLOT) begin
            slot_d = '0;
        end
    end

    assign cpu_slot_c = (slot_q == CPU_SLOT);

    // Address/control mux onto the single RAM port, keyed by the current slot.
    always_comb begin
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = bus.cpu_wdata;
        for (int p = 0; p < int'(NUM_PF); p++) begin
            if (slot_q == slot_t'(p)) begin
                ram_en_c   = 1'b1;
                ram_addr_c = {PF_W'(p), vscr_q[p][VSCR_W-1:3], bus.hcol_i};
            end
        end
        if (slot_q == MO_SLOT) begin
            ram_en_c   = 1'b1;
            ram_addr_c = bus.mo_addr_i;
        end
        if (cpu_slot_c) begin
            ram_en_c   = bus.cpu_req;
            ram_we_c   = bus.cpu_req & bus.cpu_we;
            ram_addr_c = bus.cpu_addr;
        end
    end

    vram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (AW)
    ) u_bank (
        .clk     (clk),
        .en      (ram_en_c),
        .we      (ram_we_c),
        .addr    (ram_addr_c),
        .wdata   (ram_wdata_c),
        .rdata_o (ram_rdata)
    );

    // Valid/ack flags mark the cycle the RAM word is live; hold regs keep it after.
    always_comb begin
        pf_valid_d = '0;
        mo_valid_d = (slot_q == MO_SLOT);
        cpu_ack_d  = cpu_slot_c & bus.cpu_req;
        mo_hold_d  = mo_valid_q ? ram_rdata : mo_hold_q;
        cpu_hold_d = cpu_ack_q  ? ram_rdata : cpu_hold_q;
        ctrl_d     = bus.ctrl_we ? bus.ctrl_wdata : ctrl_q;
        for (int p = 0; p < int'(NUM_PF); p++) begin
            pf_valid_d[p] = (slot_q == slot_t'(p));
            pf_hold_d[p]  = pf_valid_q[p] ? ram_rdata : pf_hold_q[p];
            vscr_d[p]     = vscr_q[p];
            if (bus.vscroll_ld[p]) begin
                vscr_d[p] = bus.vscroll_val;
            end else if (bus.line_stb) begin
                vscr_d[p] = vscr_q[p] + VSCR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            pf_valid_q <= '0;
            mo_valid_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            mo_hold_q  <= '0;
            cpu_hold_q <= '0;
            ctrl_q     <= '0;
            for (int p = 0; p < int'(NUM_PF); p++) begin
                vscr_q[p]    <= '0;
                pf_hold_q[p] <= '0;
            end
        end else begin
            slot_q     <= slot_d;
            pf_valid_q <= pf_valid_d;
            mo_valid_q <= mo_valid_d;
            cpu_ack_q  <= cpu_ack_d;
            mo_hold_q  <= mo_hold_d;
            cpu_hold_q <= cpu_hold_d;
            ctrl_q     <= ctrl_d;
            for (int p = 0; p < int'(NUM_PF); p++) begin
                vscr_q[p]    <= vscr_d[p];
                pf_hold_q[p] <= pf_hold_d[p];
            end
        end
    end

    always_comb begin
        bus.pf_data_o  = '0;
        bus.pf_fine_o  = '0;
        for (int p = 0; p < int'(NUM_PF); p++) begin
            bus.pf_data_o[p*DATA_W +: DATA_W] = pf_valid_q[p] ? ram_rdata : pf_hold_q[p];
            bus.pf_fine_o[p*3 +: 3]           = vscr_q[p][2:0];
        end
        bus.pf_valid_o = pf_valid_q;
        bus.mo_valid_o = mo_valid_q;
        bus.mo_data_o  = mo_valid_q ? ram_rdata : mo_hold_q;
        bus.cpu_ack    = cpu_ack_q;
        bus.cpu_rdata  = cpu_ack_q ? ram_rdata : cpu_hold_q;
        bus.ctrl_o     = ctrl_q;
    end

    // Row bits RW are consumed through the vscr slice in the address mux.
    if (RW + COL_W + PF_W != AW) begin : g_bad_width
        $error("address width mismatch");
    end

endmodule

// File: tb/tb_pf_vram_sequencer.sv
// Self-checking bench: behavioural slot/memory model plus directed pin-down cases.
module tb_pf_vram_sequencer;
    import vram_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned NPF   = 2;
    localparam int unsigned CW    = 6;
    localparam int unsigned S     = NPF + 2;
    localparam int unsigned AW    = ADDR_W;
    localparam int unsigned MEM_N = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    pf_vram_sequencer_if bus();

    pf_vram_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem   [MEM_N];
    bit            m_known [MEM_N];
    int            m_slot;
    int unsigned   m_vscr  [NPF];
    logic [7:0]    m_ctrl;
    bit            e_pf_valid [NPF];
    logic [DW-1:0] e_pf_data  [NPF];
    bit            e_pf_known [NPF];
    bit            e_mo_valid, e_mo_known;
    logic [DW-1:0] e_mo_data;
    bit            e_ack, e_ack_rd, e_rd_known;
    logic [DW-1:0] e_rdata;
    int unsigned   ma;

    function automatic int unsigned pf_addr(input int p, input int unsigned vscr, input int unsigned hcol);
        return (p << (ROW_W + CW)) | ((vscr >> 3) << CW) | hcol;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot = 0;
            m_ctrl = '0;
            for (int p = 0; p < NPF; p++) begin
                m_vscr[p] = 0; e_pf_valid[p] = 0; e_pf_data[p] = '0; e_pf_known[p] = 1;
            end
            e_mo_valid = 0; e_mo_data = '0; e_mo_known = 1;
            e_ack = 0; e_ack_rd = 0; e_rd_known = 0;
        end else begin
            for (int p = 0; p < NPF; p++) e_pf_valid[p] = 0;
            e_mo_valid = 0;
            e_ack = 0;
            if (m_slot < NPF) begin
                ma = pf_addr(m_slot, m_vscr[m_slot], int'(bus.hcol_i));
                e_pf_valid[m_slot] = 1;
                e_pf_data[m_slot]  = m_mem[ma];
                e_pf_known[m_slot] = m_known[ma];
            end else if (m_slot == NPF) begin
                ma = int'(bus.mo_addr_i);
                e_mo_valid = 1; e_mo_data = m_mem[ma]; e_mo_known = m_known[ma];
            end else if (bus.cpu_req) begin
                ma = int'(bus.cpu_addr);
                e_ack = 1;
                if (bus.cpu_we) begin
                    m_mem[ma] = bus.cpu_wdata; m_known[ma] = 1; e_ack_rd = 0;
                end else begin
                    e_ack_rd = 1; e_rdata = m_mem[ma]; e_rd_known = m_known[ma];
                end
            end
            for (int p = 0; p < NPF; p++) begin
                if (bus.vscroll_ld[p]) m_vscr[p] = int'(bus.vscroll_val);
                else if (bus.line_stb) m_vscr[p] = (m_vscr[p] + 1) % 512;
            end
            if (bus.ctrl_we) m_ctrl = bus.ctrl_wdata;
            m_slot = (m_slot + 1) % S;
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        check("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
        if (e_ack && e_ack_rd && e_rd_known)
            check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rdata));
        for (int p = 0; p < NPF; p++) begin
            check($sformatf("pf_valid[%0d]", p), 32'(bus.pf_valid_o[p]), 32'(e_pf_valid[p]));
            if (e_pf_known[p])
                check($sformatf("pf_data[%0d]", p), 32'(bus.pf_data_o[p*DW +: DW]), 32'(e_pf_data[p]));
            check($sformatf("pf_fine[%0d]", p), 32'(bus.pf_fine_o[p*3 +: 3]), m_vscr[p] & 7);
        end
        check("mo_valid", 32'(bus.mo_valid_o), 32'(e_mo_valid));
        if (e_mo_known) check("mo_data", 32'(bus.mo_data_o), 32'(e_mo_data));
        check("ctrl_o", 32'(bus.ctrl_o), 32'(m_ctrl));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.hcol_i = '0; bus.line_stb = 0; bus.vscroll_ld = '0; bus.vscroll_val = '0;
        bus.mo_addr_i = '0; bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.ctrl_we = 0; bus.ctrl_wdata = '0;
    endtask

    task automatic cpu_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output int lat);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        lat = 0; rd = '0;
        for (int i = 1; i <= int'(S) + 2; i++) begin
            tick();
            if (bus.cpu_ack) begin lat = i; rd = bus.cpu_rdata; break; end
        end
        bus.cpu_req = 0;
        if (lat == 0) check("cpu_op_ack_within_bound", 32'(bus.cpu_ack), 32'd1);
        else          check("cpu_op_latency_le_S", 32'(lat <= int'(S)), 32'd1);
    endtask

    task automatic wait_pf(input int p, output logic [DW-1:0] d);
        bit seen = 0;
        d = '0;
        for (int i = 0; i < 2 * int'(S); i++) begin
            tick();
            if (bus.pf_valid_o[p]) begin seen = 1; d = bus.pf_data_o[p*DW +: DW]; break; end
        end
        if (!seen) check($sformatf("pf_valid[%0d]_within_bound", p), 32'(bus.pf_valid_o[p]), 32'd1);
    endtask

    task automatic align_slot(input int s);
        for (int i = 0; i <= int'(S); i++) begin
            if (m_slot == s) break;
            tick();
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'(($urandom_range(0, 1) << 12) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 7));
    endfunction

    logic [DW-1:0] rd;
    int            lat;
    bit            rq_active;
    int            rq_wait;

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        check("rst_cpu_ack",   32'(bus.cpu_ack),    32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata),  32'd0);
        check("rst_pf_data",   32'(bus.pf_data_o),  32'd0);
        check("rst_pf_valid",  32'(bus.pf_valid_o), 32'd0);
        check("rst_pf_fine",   32'(bus.pf_fine_o),  32'd0);
        check("rst_mo_data",   32'(bus.mo_data_o),  32'd0);
        check("rst_mo_valid",  32'(bus.mo_valid_o), 32'd0);
        check("rst_ctrl",      32'(bus.ctrl_o),     32'd0);
        rst = 0;
        tick();

        bus.ctrl_we = 1; bus.ctrl_wdata = 8'h5C; tick(); bus.ctrl_we = 0;
        check("ctrl_load", 32'(bus.ctrl_o), 32'h5C);

        // Write then read back the same word.
        cpu_op(1, 13'h040, 16'h1234, rd, lat);
        cpu_op(0, 13'h040, 16'h0000, rd, lat);
        check("wr_rd_0x040", 32'(rd), 32'h1234);

        cpu_op(1, 13'h00C5, 16'hBEEF, rd, lat);
        cpu_op(1, 13'h0005, 16'hA5A5, rd, lat);
        cpu_op(1, 13'h1085, 16'h5A5A, rd, lat);
        cpu_op(1, 13'h00AA, 16'h0777, rd, lat);

        // pf0 row 3 col 5 via vscr=24, hcol=5.
        bus.hcol_i = 6'd5;
        bus.vscroll_ld = 2'b01; bus.vscroll_val = 9'd24; tick(); bus.vscroll_ld = '0;
        wait_pf(0, rd);
        check("pf0_row3_col5", 32'(rd), 32'hBEEF);

        // Scroll wrap 0x1FF -> 0x000.
        bus.vscroll_ld = 2'b01; bus.vscroll_val = 9'h1FF; tick(); bus.vscroll_ld = '0;
        check("fine0_after_ld_1ff", 32'(bus.pf_fine_o[2:0]), 32'd7);
        bus.line_stb = 1; tick(); bus.line_stb = 0;
        check("fine0_after_wrap", 32'(bus.pf_fine_o[2:0]), 32'd0);
        wait_pf(0, rd);
        check("pf0_row0_after_wrap", 32'(rd), 32'hA5A5);

        // Load wins over line strobe.
        bus.vscroll_ld = 2'b10; bus.vscroll_val = 9'h100; tick();
        bus.vscroll_ld = 2'b10; bus.vscroll_val = 9'h010; bus.line_stb = 1; tick();
        bus.vscroll_ld = '0; bus.line_stb = 0;
        check("fine1_load_wins", 32'(bus.pf_fine_o[5:3]), 32'd0);
        wait_pf(1, rd);
        check("pf1_row2_load_wins", 32'(rd), 32'h5A5A);

        // Request raised right after the CPU slot: worst-case latency.
        align_slot(0);
        cpu_op(0, 13'h040, 16'h0000, rd, lat);
        check("worst_case_latency", 32'(lat), 32'd4);
        check("worst_case_rdata", 32'(rd), 32'h1234);

        // Reset during CPU slot with a pending write.
        align_slot(int'(S) - 1);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 13'h00AA; bus.cpu_wdata = 16'hDEAD;
        #1 rst = 1;
        #1;
        check("abort_cpu_ack",   32'(bus.cpu_ack),    32'd0);
        check("abort_cpu_rdata", 32'(bus.cpu_rdata),  32'd0);
        check("abort_pf_data",   32'(bus.pf_data_o),  32'd0);
        check("abort_pf_valid",  32'(bus.pf_valid_o), 32'd0);
        check("abort_mo_data",   32'(bus.mo_data_o),  32'd0);
        check("abort_ctrl",      32'(bus.ctrl_o),     32'd0);
        repeat (2) begin
            tick();
            check("abort_no_ack", 32'(bus.cpu_ack), 32'd0);
        end
        bus.cpu_req = 0;
        rst = 0;
        tick();
        cpu_op(0, 13'h00AA, 16'h0000, rd, lat);
        check("ram_retained", 32'(rd), 32'h0777);

        // Randomised traffic against the model.
        rq_active = 0; rq_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rq_active) begin
                rq_wait++;
                if (bus.cpu_ack) begin
                    check("rand_latency_le_S", 32'(rq_wait <= int'(S)), 32'd1);
                    rq_active = 0; bus.cpu_req = 0;
                end else if (rq_wait > int'(S)) begin
                    check("rand_ack_within_bound", 32'(bus.cpu_ack), 32'd1);
                    rq_active = 0; bus.cpu_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                rq_active = 1; rq_wait = 0;
                bus.cpu_req = 1; bus.cpu_we = 1'($urandom_range(0, 1));
                bus.cpu_addr = rand_addr(); bus.cpu_wdata = DW'($urandom);
            end
            bus.hcol_i     = 6'($urandom_range(0, 7));
            bus.line_stb   = ($urandom_range(0, 7) == 0);
            bus.vscroll_ld = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.vscroll_val = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                                          : 9'($urandom_range(0, 63));
            bus.mo_addr_i  = rand_addr();
            bus.ctrl_we    = ($urandom_range(0, 15) == 0);
            bus.ctrl_wdata = 8'($urandom);
            tick();
        end
        idle_inputs();
        repeat (2 * S) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pf_vram_sequencer.md
PF_VRAM_SEQUENCER -- requirements
Module: pf_vram_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning VRAM word width.
REQ-002 The block SHALL have parameter NUM_PF, default 2 (power of 2, >=2), meaning playfield channel count.
REQ-003 The block SHALL have parameter COL_W, default 6, meaning horizontal tile-column bits.
REQ-004 The block SHALL have parameter VSCR_W, default 9, meaning vertical scroll counter width; ROW_W = VSCR_W-3; ADDR_W = clog2(NUM_PF)+ROW_W+COL_W.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  system clock, sole clock;
  rst  in  1  asynchronous, active-high reset;
  hcol_i  in  COL_W  current tile column for playfield fetches;
  line_stb  in  1  one-cycle per-scanline strobe;
  vscroll_ld  in  NUM_PF  per-playfield scroll load;
  vscroll_val  in  VSCR_W  scroll load value;
  mo_addr_i  in  ADDR_W  motion-object fetch address;
  cpu_req  in  1  CPU access request, held until ack;
  cpu_we  in  1  1=write, 0=read;
  cpu_addr  in  ADDR_W  CPU word address;
  cpu_wdata  in  DATA_W  CPU write data;
  cpu_ack  out  1  one-cycle completion pulse;
  cpu_rdata  out  DATA_W  read data, valid with cpu_ack;
  pf_data_o  out  NUM_PF*DATA_W  per-playfield fetched word;
  pf_valid_o  out  NUM_PF  per-playfield one-cycle valid;
  pf_fine_o  out  NUM_PF*3  per-playfield fine vertical offset;
  mo_data_o  out  DATA_W  motion-object word;
  mo_valid_o  out  1  motion-object valid;
  ctrl_we  in  1  control register write strobe;
  ctrl_wdata  in  8  control register data;
  ctrl_o  out  8  control register contents.

Function
REQ-006 A slot counter SHALL cycle 0..S-1, S=NUM_PF+2, advancing every clk, wrapping S-1->0.
REQ-007 Slot p<NUM_PF SHALL read address {p, vscr[p][VSCR_W-1:3], hcol_i}.
REQ-008 Slot NUM_PF SHALL read mo_addr_i; slot NUM_PF+1 SHALL be the CPU slot.
REQ-009 The internal RAM SHALL be single-port, 2^ADDR_W x DATA_W, synchronous read, one-cycle latency.
REQ-010 Read data for slot p SHALL appear on pf_data_o[p] with pf_valid_o[p] high exactly one cycle after slot p; pf_data_o holds until next fetch.
REQ-011 mo_data_o/mo_valid_o SHALL follow the same one-cycle rule for slot NUM_PF.
REQ-012 If cpu_req is high in the CPU slot, the access SHALL execute that slot; cpu_ack SHALL pulse the next cycle, with cpu_rdata valid for reads.
REQ-013 If cpu_req is low in the CPU slot, the slot SHALL idle with no RAM write.
REQ-014 Worst-case cpu_req-to-cpu_ack latency SHALL be S cycles; requests SHALL never be dropped or served twice per ack.
REQ-015 A read following a write to the same address SHALL return the written data.
REQ-016 vscr[p] SHALL load vscroll_val on vscroll_ld[p], else increment modulo 2^VSCR_W on line_stb; load wins on coincidence.
REQ-017 pf_fine_o[p] SHALL equal vscr[p][2:0].
REQ-018 ctrl_o SHALL load ctrl_wdata on ctrl_we.

Reset
REQ-019 rst SHALL asynchronously force slot counter 0, all vscr 0, cpu_ack 0, cpu_rdata 0, pf_data_o 0, pf_valid_o 0, mo_data_o 0, mo_valid_o 0, ctrl_o 0.
REQ-020 RAM contents SHALL be unaffected by rst; an in-flight CPU access aborted by rst SHALL NOT ack.

Structure
REQ-021 Slot-index typedef and the clog2-derived ADDR_W/ROW_W constants SHALL live in shared package vram_pkg.
REQ-022 The RAM SHALL be a sub-module named vram_bank.

Verification
REQ-023 NUM_PF=2: CPU write 0x1234 to 0x040 then read 0x040 -> cpu_rdata=0x1234 with cpu_ack.
REQ-024 vscroll_ld[0] with 0x1FF, one line_stb -> vscr[0]=0x000, pf_fine_o[0]=0.
REQ-025 vscroll_ld[1] and line_stb same cycle, value 0x010 -> vscr[1]=0x010.
REQ-026 cpu_req raised one cycle after CPU slot -> cpu_ack exactly S=4 cycles later; playfield/MO valids unaffected.
REQ-027 Preload pf0 row3 col5 = 0xBEEF, vscr[0]=24, hcol_i=5 -> pf_valid_o[0] with pf_data_o[0]=0xBEEF one cycle after slot 0.
REQ-028 rst asserted during CPU slot with cpu_req high -> no ack, all outputs 0, RAM data retained.
